// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state encoding and frame data width.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the head entry while non-empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Head is forced to zero while empty so the output is defined without resetting storage.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; only pointers and count define what is valid, which keeps it plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, framing check and a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) and the rx_parity_err output.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 51,
  parameter int FIFO_DEPTH   = 4
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic                            rx_clk,
  input  logic                            rx_rst_n,
  input  logic                            rx_serial,
  output logic [DATA_W-1:0]               rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            rx_frame_err,
  output logic                            rx_overflow,
  output logic                            rx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_fifo_count
`ifdef UART_RX_PARITY_EN
  ,
  output logic                            rx_parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic              r_sync1;
  logic              r_rxs;
  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err;
  logic              r_overflow;
  logic              r_busy;

  logic w_mid;
  logic w_last;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_push;
  logic w_ferr_set;
  logic w_fifo_full;
  logic w_fifo_empty;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic r_par_err;
  logic r_parity_err;
  logic w_par_sample;
  logic w_perr_set;
`endif

  assign w_mid  = (r_cnt == CNT_MID);
  assign w_last = (r_cnt == CNT_LAST);

  // Two-flop synchronizer; resets to the idle level so reset itself never looks like a start bit.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
    w_perr_set   = 1'b0;
`endif
    case (r_state)
      WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (r_rxs) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rxs) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_mid) begin
          w_cnt_clr    = 1'b1;
          w_state_next = r_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_last) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_last) begin
          w_cnt_clr    = 1'b1;
          w_par_sample = 1'b1;
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_last) begin
          w_cnt_clr = 1'b1;
          if (!r_rxs) begin
            // A low stop bit may be a break; wait for the line to return high before hunting again.
            w_ferr_set   = 1'b1;
            w_state_next = WAIT_IDLE;
          end else begin
            w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par_err) begin
              w_perr_set = 1'b1;
            end else begin
              w_push = 1'b1;
            end
`else
            w_push = 1'b1;
`endif
          end
        end
      end
      default: begin
        w_state_next = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (w_shift_en) begin
        r_shift[r_idx] <= r_rxs;
        r_idx          <= r_idx + 3'd1;
      end else if (r_state != DATA) begin
        r_idx <= '0;
      end
    end
  end

  // Status pulses are registered; busy tracks the state register so it reads 0 during reset.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= w_ferr_set;
      r_overflow  <= w_push && w_fifo_full && !(rx_ready && rx_valid);
      r_busy      <= (w_state_next != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) begin
        r_par_err <= ((^{r_shift, r_rxs}) != PAR_ODD);
      end else if (r_state == IDLE) begin
        r_par_err <= 1'b0;
      end
      r_parity_err <= w_perr_set;
    end
  end

  assign rx_parity_err = r_parity_err;
`endif

  uart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (rx_clk),
    .i_rst_n (rx_rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (rx_fifo_count)
  );

  assign rx_valid     = !w_fifo_empty;
  assign rx_frame_err = r_frame_err;
  assign rx_overflow  = r_overflow;
  assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: vector table, corner sequences and randomized frames vs a queue model.
module tb_uart_rx_buffered;

  localparam int CPB   = 51;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam bit PAR_ODD = 1'b0;
`else
  localparam bit PAR_EN  = 1'b0;
`endif

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          serial = 1'b1;
  logic          ready  = 1'b1;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          ferr;
  logic          ovf;
  logic          busy;
  logic [CW-1:0] fcount;
`ifdef UART_RX_PARITY_EN
  logic          perr;
`endif

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .rx_clk        (clk),
    .rx_rst_n      (rst_n),
    .rx_serial     (serial),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (ready),
    .rx_frame_err  (ferr),
    .rx_overflow   (ovf),
    .rx_busy       (busy),
    .rx_fifo_count (fcount)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err (perr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes the receiver should be holding, in order, plus expected pulse totals.
  logic [7:0] model_q[$];
  int exp_ferr = 0, exp_ovf = 0, exp_perr = 0;
  int n_ferr = 0, n_ovf = 0, n_perr = 0, n_rx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: counts pulse cycles and compares every handed-over byte with the model head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) n_ferr++;
      if (ovf)  n_ovf++;
`ifdef UART_RX_PARITY_EN
      if (perr) n_perr++;
`endif
      if (rx_valid && ready) begin
        n_rx++;
        if (model_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %02h expected none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(model_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    tick(CPB);
  endtask

  // Drives one frame; a zero stop bit keeps the line low for three bit times in total.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD ^ par_bad);
`endif
    if (!stop)                          exp_ferr++;
    else if (par_bad && PAR_EN)         exp_perr++;
    else if (model_q.size() == DEPTH)   exp_ovf++;
    else                                model_q.push_back(d);
    drive_bit(stop);
    if (!stop) tick(2 * CPB);
    serial = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 0);
    check({tag, "_data"},  32'(rx_data),  0);
    check({tag, "_count"}, 32'(fcount),   0);
    check({tag, "_busy"},  32'(busy),     0);
    check({tag, "_ferr"},  32'(ferr),     0);
    check({tag, "_ovf"},   32'(ovf),      0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   lat, cyc, rx0, f0, o0, p0;

    vecs[0] = '{8'hAB, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 0};
    vecs[7] = '{8'h5A, 1'b0, 0, 1};
    vecs[8] = '{8'hC3, 1'b1, 1, 0};

    // Reset state
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(5);
    check_idle_outputs("post_reset");

    // First frame latency from the start-bit falling edge
    rx0 = n_rx; f0 = n_ferr; o0 = n_ovf;
    lat = 0;
    fork
      send_frame(8'hAB, 1'b1, 1'b0);
      begin
        while (!rx_valid && lat < 600) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    tick(CPB);
    check("ab_latency_le_490", 32'(lat <= 490), 1);
    check("ab_latency_ge_480", 32'(lat >= 480), 1);
    check("ab_bytes", 32'(n_rx - rx0), 1);
    check("ab_ferr",  32'(n_ferr - f0), 0);
    check("ab_ovf",   32'(n_ovf - o0), 0);

    // Start-bit glitch: 10 low cycles must be rejected silently
    rx0 = n_rx; f0 = n_ferr;
    serial = 1'b0;
    tick(10);
    serial = 1'b1;
    check("glitch_busy_set", 32'(busy), 1);
    cyc = 0;
    while (busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("glitch_busy_clear", 32'(busy), 0);
    tick(CPB);
    check("glitch_bytes", 32'(n_rx - rx0), 0);
    check("glitch_ferr",  32'(n_ferr - f0), 0);

    // Table-driven frames, including a framing error followed by a good frame
    for (int i = 0; i < 9; i++) begin
      rx0 = n_rx; f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      tick(2 * CPB);
      check($sformatf("vec%0d_bytes", i), 32'(n_rx - rx0),   32'(vecs[i].exp_bytes));
      check($sformatf("vec%0d_ferr", i),  32'(n_ferr - f0),   32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_count", i), 32'(fcount), 0);
      check($sformatf("vec%0d_busy", i),  32'(busy), 0);
    end

    // Overflow: five frames into a four-entry FIFO with the consumer stalled
    ready = 1'b0;
    rx0 = n_rx; o0 = n_ovf;
    for (int d = 1; d <= 5; d++) begin
      send_frame(8'(d), 1'b1, 1'b0);
      tick(CPB);
    end
    check("ovf_count",  32'(fcount), 4);
    check("ovf_pulses", 32'(n_ovf - o0), 1);
    check("ovf_valid",  32'(rx_valid), 1);
    check("ovf_head",   32'(rx_data), 32'h01);
    ready = 1'b1;
    tick(8);
    check("drain_pops",  32'(n_rx - rx0), 4);
    check("drain_valid", 32'(rx_valid), 0);
    check("drain_count", 32'(fcount), 0);

    // Reset during data bit 4 of 0x0F (line low), released while the line is still low
    rx0 = n_rx; f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    serial = 1'b0;
    tick(25);
    rst_n = 1'b0;
    model_q.delete();
    tick(2);
    check_idle_outputs("midreset");
    tick(4 * CPB - 20 - 27);
    rst_n = 1'b1;
    tick(20);
    serial = 1'b1;
    tick(3 * CPB);
    check("midreset_bytes", 32'(n_rx - rx0), 0);
    check("midreset_ferr",  32'(n_ferr - f0), 0);
    check("midreset_busy",  32'(busy), 0);
    rx0 = n_rx;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(CPB);
    check("after_reset_bytes", 32'(n_rx - rx0), 1);
    check("after_reset_count", 32'(fcount), 0);
    exp_ferr = n_ferr; exp_ovf = n_ovf; exp_perr = n_perr;

`ifdef UART_RX_PARITY_EN
    // Parity: 0xAB has five ones, so even parity needs a 1
    rx0 = n_rx; p0 = n_perr;
    send_frame(8'hAB, 1'b1, 1'b1);
    tick(CPB);
    check("par_bad_pulse", 32'(n_perr - p0), 1);
    check("par_bad_bytes", 32'(n_rx - rx0), 0);
    send_frame(8'hAB, 1'b1, 1'b0);
    tick(CPB);
    check("par_good_bytes", 32'(n_rx - rx0), 1);
    check("par_good_pulse", 32'(n_perr - p0), 1);
`else
    p0 = 0;
`endif

    // Randomized frames with occasional bad stop/parity bits and consumer stalls
    for (int k = 0; k < 16; k++) begin
      ready = ($urandom_range(0, 2) != 0);
      tick(8);
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) == 0));
      tick(CPB);
    end
    ready = 1'b1;
    tick(8);
    check("rand_ferr_total", 32'(n_ferr), 32'(exp_ferr));
    check("rand_ovf_total",  32'(n_ovf),  32'(exp_ovf));
    check("rand_perr_total", 32'(n_perr), 32'(exp_perr));
    check("rand_model_left", 32'(model_q.size()), 0);
    check("rand_count",      32'(fcount), 0);
    check("rand_valid",      32'(rx_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
